// File: rtl/vie_int_ctrl_pkg.sv
// Shared CP0 definitions: register addresses, interrupt-controller FSM encodings
// and the pending-bit priority encoder.
package vie_int_ctrl_pkg;

  localparam logic [4:0] CR_COUNT   = 5'd9;
  localparam logic [4:0] CR_COMPARE = 5'd11;
  localparam logic [4:0] CR_STATUS  = 5'd12;
  localparam logic [4:0] CR_CAUSE   = 5'd13;
  localparam logic [4:0] CR_EPC     = 5'd14;

  typedef enum logic [1:0] {
    IC_IDLE     = 2'd0,
    IC_REQ      = 2'd1,
    IC_WAIT_EXL = 2'd2,
    IC_HANDLER  = 2'd3
  } ic_state_e;

  // Highest set bit wins; an all-zero vector encodes as 0.
  function automatic logic [2:0] prio_enc8(logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vie_int_ctrl_if.sv
// Signal bundle between CP0/write-back (master) and the interrupt controller (slave).
interface vie_int_ctrl_if;
  logic [5:0] ext_int_in;
  logic       timer_hit;
  logic       compare_wr;
  logic       cause_sw_wr;
  logic [1:0] cause_sw_wdata;
  logic [7:0] status_im;
  logic       status_ie;
  logic       status_exl;
  logic       int_ack;
  logic [7:0] cause_ip;
  logic       cause_ti;
  logic       int_req;
  logic [2:0] int_src;
  logic [1:0] ic_state;

  modport master (
    output ext_int_in, timer_hit, compare_wr, cause_sw_wr, cause_sw_wdata,
           status_im, status_ie, status_exl, int_ack,
    input  cause_ip, cause_ti, int_req, int_src, ic_state
  );

  modport slave (
    input  ext_int_in, timer_hit, compare_wr, cause_sw_wr, cause_sw_wdata,
           status_im, status_ie, status_exl, int_ack,
    output cause_ip, cause_ti, int_req, int_src, ic_state
  );
endinterface

// File: rtl/vie_sync_bit.sv
// Single-bit synchroniser, Depth flops deep, with synchronous active-low clear.
module vie_sync_bit #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[Depth-2:0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= stage_d;
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vie_int_ctrl.sv
// CP0 interrupt controller: synchronises HW lines, owns Cause.TI/IP and raises one
// request per handler entry towards the write-back stage.
module vie_int_ctrl
  import vie_int_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clock,
  input logic           resetn,
  vie_int_ctrl_if.slave bus
);

  logic [5:0] ext_s;
  logic       ti_q, ti_d;
  logic [1:0] sw_q, sw_d;
  logic [7:0] cause_ip, masked;
  logic       enable;
  ic_state_e  state_q;

  for (genvar i = 0; i < 6; i++) begin : g_sync
    vie_sync_bit #(
      .Depth (SYNC_STAGES)
    ) u_sync (
      .clk_i  (clock),
      .rst_ni (resetn),
      .d_i    (bus.ext_int_in[i]),
      .q_o    (ext_s[i])
    );
  end

  // A Compare write in the same cycle as a timer hit leaves TI clear.
  always_comb begin
    ti_d = ti_q;
    if (bus.compare_wr)     ti_d = 1'b0;
    else if (bus.timer_hit) ti_d = 1'b1;
    sw_d = bus.cause_sw_wr ? bus.cause_sw_wdata : sw_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ti_q <= 1'b0;
      sw_q <= 2'b00;
    end else begin
      ti_q <= ti_d;
      sw_q <= sw_d;
    end
  end

  assign cause_ip = {ext_s[5] | ti_q, ext_s[4:0], sw_q};
  assign masked   = cause_ip & bus.status_im;
  assign enable   = bus.status_ie & ~bus.status_exl;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IC_IDLE;
    end else begin
      unique case (state_q)
        IC_IDLE: begin
          if ((masked != 8'h00) && enable) state_q <= IC_REQ;
        end
        IC_REQ: begin
          // Level-sensitive sources: withdraw if the cause vanishes before the ack.
          if (bus.int_ack)                          state_q <= IC_WAIT_EXL;
          else if ((masked == 8'h00) || !enable)    state_q <= IC_IDLE;
        end
        IC_WAIT_EXL: begin
          if (bus.status_exl) state_q <= IC_HANDLER;
        end
        IC_HANDLER: begin
          if (!bus.status_exl) state_q <= IC_IDLE;
        end
        default: state_q <= IC_IDLE;
      endcase
    end
  end

  assign bus.cause_ip = cause_ip;
  assign bus.cause_ti = ti_q;
  assign bus.int_req  = (state_q == IC_REQ);
  assign bus.int_src  = prio_enc8(masked);
  assign bus.ic_state = state_q;

endmodule

// File: tb/tb_vie_int_ctrl.sv
// Directed bench for vie_int_ctrl with SYNC_STAGES = 2; expected values hand-computed.
module tb_vie_int_ctrl;

  logic clock = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  vie_int_ctrl_if bus ();

  vie_int_ctrl #(
    .SYNC_STAGES (2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    resetn             = 1'b0;
    bus.ext_int_in     = 6'h3F;
    bus.timer_hit      = 1'b0;
    bus.compare_wr     = 1'b0;
    bus.cause_sw_wr    = 1'b0;
    bus.cause_sw_wdata = 2'b00;
    bus.status_im      = 8'h00;
    bus.status_ie      = 1'b0;
    bus.status_exl     = 1'b0;
    bus.int_ack        = 1'b0;

    // Reset
    tick();
    tick();
    check_eq("rst_cause_ip", 32'(bus.cause_ip), 32'h00);
    check_eq("rst_cause_ti", 32'(bus.cause_ti), 32'h0);
    check_eq("rst_int_req", 32'(bus.int_req), 32'h0);
    check_eq("rst_int_src", 32'(bus.int_src), 32'h0);
    check_eq("rst_ic_state", 32'(bus.ic_state), 32'h0);
    resetn = 1'b1;
    tick();
    check_eq("sync_lat_1", 32'(bus.cause_ip), 32'h00);
    tick();
    check_eq("sync_lat_2", 32'(bus.cause_ip), 32'hFC);
    bus.ext_int_in = 6'h00;
    tick();
    tick();
    check_eq("ext_clear", 32'(bus.cause_ip), 32'h00);

    // HW2 request / ack / EXL handshake
    bus.status_im  = 8'h10;
    bus.status_ie  = 1'b1;
    bus.ext_int_in = 6'h04;
    tick();
    check_eq("hw2_e0_req", 32'(bus.int_req), 32'h0);
    tick();
    check_eq("hw2_e1_ip", 32'(bus.cause_ip), 32'h10);
    check_eq("hw2_e1_src", 32'(bus.int_src), 32'h4);
    check_eq("hw2_e1_req", 32'(bus.int_req), 32'h0);
    tick();
    check_eq("hw2_req", 32'(bus.int_req), 32'h1);
    check_eq("hw2_src", 32'(bus.int_src), 32'h4);
    check_eq("hw2_state_req", 32'(bus.ic_state), 32'h1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check_eq("ack_req_drop", 32'(bus.int_req), 32'h0);
    check_eq("ack_state", 32'(bus.ic_state), 32'h2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check_eq("stray_ack_state", 32'(bus.ic_state), 32'h2);
    bus.status_exl = 1'b1;
    tick();
    check_eq("exl_state", 32'(bus.ic_state), 32'h3);
    check_eq("exl_req", 32'(bus.int_req), 32'h0);
    bus.status_exl = 1'b0;
    tick();
    check_eq("eret_state", 32'(bus.ic_state), 32'h0);
    tick();
    check_eq("rearm_state", 32'(bus.ic_state), 32'h1);

    // Withdrawal: line drops before ack
    bus.ext_int_in = 6'h00;
    tick();
    check_eq("wd_a_state", 32'(bus.ic_state), 32'h1);
    tick();
    check_eq("wd_b_state", 32'(bus.ic_state), 32'h1);
    check_eq("wd_b_src", 32'(bus.int_src), 32'h0);
    tick();
    check_eq("wd_c_state", 32'(bus.ic_state), 32'h0);
    check_eq("wd_c_req", 32'(bus.int_req), 32'h0);

    // Timer flag
    bus.timer_hit = 1'b1;
    tick();
    bus.timer_hit = 1'b0;
    check_eq("ti_set", 32'(bus.cause_ti), 32'h1);
    check_eq("ti_ip7", 32'(bus.cause_ip), 32'h80);
    bus.timer_hit  = 1'b1;
    bus.compare_wr = 1'b1;
    tick();
    bus.timer_hit  = 1'b0;
    bus.compare_wr = 1'b0;
    check_eq("ti_clear_wins", 32'(bus.cause_ti), 32'h0);
    check_eq("ti_clear_ip", 32'(bus.cause_ip), 32'h00);

    // Priority and masking
    bus.status_im      = 8'hFF;
    bus.cause_sw_wr    = 1'b1;
    bus.cause_sw_wdata = 2'b01;
    bus.ext_int_in     = 6'h20;
    tick();
    bus.cause_sw_wr = 1'b0;
    check_eq("sw_ip", 32'(bus.cause_ip), 32'h01);
    check_eq("sw_src", 32'(bus.int_src), 32'h0);
    tick();
    tick();
    check_eq("prio_ip", 32'(bus.cause_ip), 32'h81);
    check_eq("prio_src", 32'(bus.int_src), 32'h7);
    check_eq("prio_req", 32'(bus.int_req), 32'h1);
    bus.status_im = 8'h01;
    #1;
    check_eq("mask_src", 32'(bus.int_src), 32'h0);
    check_eq("mask_req", 32'(bus.int_req), 32'h1);
    tick();
    check_eq("mask_req_hold", 32'(bus.int_req), 32'h1);

    // Reset while requesting
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_eq("midrst_req", 32'(bus.int_req), 32'h0);
    check_eq("midrst_state", 32'(bus.ic_state), 32'h0);
    check_eq("midrst_ip", 32'(bus.cause_ip), 32'h00);

    // EXL gating
    bus.status_exl     = 1'b1;
    bus.cause_sw_wr    = 1'b1;
    bus.cause_sw_wdata = 2'b01;
    tick();
    bus.cause_sw_wr = 1'b0;
    check_eq("exlg_ip0", 32'(bus.cause_ip[0]), 32'h1);
    check_eq("exlg_req_0", 32'(bus.int_req), 32'h0);
    tick();
    check_eq("exlg_req_1", 32'(bus.int_req), 32'h0);
    bus.status_exl = 1'b0;
    #1;
    check_eq("exlg_req_comb", 32'(bus.int_req), 32'h0);
    tick();
    check_eq("exlg_req_rise", 32'(bus.int_req), 32'h1);
    check_eq("exlg_src", 32'(bus.int_src), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
